// File: rtl/lsu_if.sv
// Bus bundle between the load/store unit, the execute stage and the memory data port.
// The LSU takes the master view (it initiates memory traffic and answers the core);
// the environment (core + memory) takes the slave view.
`timescale 1ns/1ps
interface lsu_if;
  // core request / response
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  // memory data port
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_wdata;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  modport master (
    input  req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one access in flight, 8-byte-aligned memory requests with byte
// strobes, load alignment/extension, misalignment and timeout detection.
//
//   state | meaning
//   IDLE  | ready for a core request
//   REQ   | memory request presented, waiting for mem_ready
//   WAIT  | load issued, waiting for mem_rvalid
//   RESP  | single-cycle response to the core
`timescale 1ns/1ps
module lsu #(
  parameter int TIMEOUT = 256
) (
  input logic    clk,
  input logic    rst,
  lsu_if.master  bus
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          wen_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [2:0]    off_q;

  logic          misaligned;
  logic [7:0]    mask_base;
  logic [7:0]    wmask_next;
  logic [63:0]   wdata_next;
  logic [63:0]   load_shift;
  logic [63:0]   load_ext;

  // Decode of the incoming request: alignment check and lane placement.
  always_comb begin
    misaligned = 1'b0;
    mask_base  = 8'h01;
    case (bus.req_size)
      2'd0: begin misaligned = 1'b0;                mask_base = 8'h01; end
      2'd1: begin misaligned = bus.req_addr[0];     mask_base = 8'h03; end
      2'd2: begin misaligned = |bus.req_addr[1:0];  mask_base = 8'h0F; end
      default: begin misaligned = |bus.req_addr[2:0]; mask_base = 8'hFF; end
    endcase
    wmask_next = mask_base << bus.req_addr[2:0];
    wdata_next = bus.req_wdata << {bus.req_addr[2:0], 3'b000};
  end

  // Read data extraction from the latched offset/size/signedness.
  always_comb begin
    load_shift = bus.mem_rdata >> {off_q, 3'b000};
    load_ext   = load_shift;
    case (size_q)
      2'd0: load_ext = uns_q ? {56'd0, load_shift[7:0]}
                             : {{56{load_shift[7]}}, load_shift[7:0]};
      2'd1: load_ext = uns_q ? {48'd0, load_shift[15:0]}
                             : {{48{load_shift[15]}}, load_shift[15:0]};
      2'd2: load_ext = uns_q ? {32'd0, load_shift[31:0]}
                             : {{32{load_shift[31]}}, load_shift[31:0]};
      default: load_ext = load_shift;
    endcase
  end

  // Access sequencer with registered outputs and the REQ+WAIT timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      wen_q          <= 1'b0;
      size_q         <= 2'd0;
      uns_q          <= 1'b0;
      off_q          <= 3'd0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      bus.mem_valid  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wen    <= 1'b0;
      bus.mem_wmask  <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            wen_q         <= bus.req_wen;
            size_q        <= bus.req_size;
            uns_q         <= bus.req_unsigned;
            off_q         <= bus.req_addr[2:0];
            if (misaligned) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              state         <= REQ;
              cnt           <= '0;
              bus.mem_valid <= 1'b1;
              bus.mem_addr  <= {bus.req_addr[31:3], 3'b000};
              bus.mem_wen   <= bus.req_wen;
              bus.mem_wmask <= bus.req_wen ? wmask_next : 8'h00;
              bus.mem_wdata <= bus.req_wen ? wdata_next : 64'd0;
            end
          end
        end
        REQ: begin
          // A completed store handshake wins over a simultaneous timeout; a load
          // still needs its data, so the timeout takes precedence there.
          if (bus.mem_ready && wen_q) begin
            state          <= RESP;
            bus.mem_valid  <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
          end else if (cnt == CNT_LAST) begin
            state          <= RESP;
            bus.mem_valid  <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (bus.mem_ready) begin
              state         <= WAIT;
              bus.mem_valid <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= load_ext;
          end else if (cnt == CNT_LAST) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
          bus.req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu (TIMEOUT=8): a vector table drives accesses while acting as the
// memory; expected responses go into a scoreboard queue at the accept edge and are
// popped by a response monitor that also checks the response arrival time.
`timescale 1ns/1ps
module tb_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if bus();
  lsu #(.TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string       name;
    logic        wen;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          stall;
    int          rdly;
    logic        noresp;
    logic        mem_op;
    logic [7:0]  exp_wmask;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    longint      t;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  vec_t vecs[15];

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Response monitor: every resp_valid must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      check(sb.size() != 0, "resp_expected", 64'(sb.size()), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check(bus.resp_rdata === e.rdata, "resp_rdata", bus.resp_rdata, e.rdata);
        check(bus.resp_err === e.err, "resp_err", 64'(bus.resp_err), 64'(e.err));
        check(longint'($time) == e.t, "resp_time", 64'($time), 64'(e.t));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t e;
    logic [31:0] exp_addr;
    exp_addr = {v.addr[31:3], 3'b000};
    @(negedge clk);
    check(bus.req_ready === 1'b1, {v.name, "/ready_idle"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid    = 1'b1;
    bus.req_wen      = v.wen;
    bus.req_addr     = v.addr;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_wdata    = v.wdata;
    bus.mem_ready    = 1'b0;
    bus.mem_rvalid   = 1'b0;
    @(posedge clk);
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    e.t     = longint'($time) + longint'((v.exp_lat - 1) * 10 + 5);
    sb.push_back(e);
    #1;
    bus.req_valid    = 1'b0;
    bus.req_addr     = $urandom;
    bus.req_wdata    = {$urandom, $urandom};
    bus.req_size     = 2'($urandom);
    bus.req_wen      = 1'($urandom);
    bus.req_unsigned = 1'($urandom);
    if (v.mem_op) begin
      for (int i = 0; i <= v.stall; i++) begin
        @(negedge clk);
        if (i == 0)
          check(bus.req_ready === 1'b0, {v.name, "/ready_busy"}, 64'(bus.req_ready), 64'd0);
        check(bus.mem_valid === 1'b1, {v.name, "/mem_valid"}, 64'(bus.mem_valid), 64'd1);
        check(bus.mem_addr === exp_addr, {v.name, "/mem_addr"}, 64'(bus.mem_addr), 64'(exp_addr));
        check(bus.mem_wen === v.wen, {v.name, "/mem_wen"}, 64'(bus.mem_wen), 64'(v.wen));
        check(bus.mem_wmask === v.exp_wmask, {v.name, "/mem_wmask"}, 64'(bus.mem_wmask), 64'(v.exp_wmask));
        if (v.wen)
          check(bus.mem_wdata === v.exp_wdata, {v.name, "/mem_wdata"}, bus.mem_wdata, v.exp_wdata);
        bus.mem_ready = (i == v.stall);
      end
      @(negedge clk);
      bus.mem_ready = 1'b0;
      check(bus.mem_valid === 1'b0, {v.name, "/mem_valid_drop"}, 64'(bus.mem_valid), 64'd0);
      if (!v.wen) begin
        for (int j = 0; j <= v.rdly; j++) begin
          bus.mem_rvalid = (j == v.rdly) && !v.noresp;
          bus.mem_rdata  = bus.mem_rvalid ? v.rdata : {$urandom, $urandom};
          @(negedge clk);
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = {$urandom, $urandom};
      end
    end else begin
      @(negedge clk);
      check(bus.mem_valid === 1'b0, {v.name, "/no_mem_req"}, 64'(bus.mem_valid), 64'd0);
      check(bus.req_ready === 1'b0, {v.name, "/ready_busy"}, 64'(bus.req_ready), 64'd0);
    end
    for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge clk);
    check(sb.size() == 0, {v.name, "/resp_seen"}, 64'(sb.size()), 64'd0);
    sb.delete();
    @(negedge clk);
    check(bus.req_ready === 1'b1, {v.name, "/ready_back"}, 64'(bus.req_ready), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(bus.req_ready === 1'b1, {tag, "/req_ready"}, 64'(bus.req_ready), 64'd1);
    check(bus.resp_valid === 1'b0, {tag, "/resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check(bus.resp_err === 1'b0, {tag, "/resp_err"}, 64'(bus.resp_err), 64'd0);
    check(bus.resp_rdata === 64'd0, {tag, "/resp_rdata"}, bus.resp_rdata, 64'd0);
    check(bus.mem_valid === 1'b0, {tag, "/mem_valid"}, 64'(bus.mem_valid), 64'd0);
    check(bus.mem_addr === 32'd0, {tag, "/mem_addr"}, 64'(bus.mem_addr), 64'd0);
    check(bus.mem_wen === 1'b0, {tag, "/mem_wen"}, 64'(bus.mem_wen), 64'd0);
    check(bus.mem_wmask === 8'd0, {tag, "/mem_wmask"}, 64'(bus.mem_wmask), 64'd0);
    check(bus.mem_wdata === 64'd0, {tag, "/mem_wdata"}, bus.mem_wdata, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    //          name          wen addr      sz uns wdata                    rdata                    st rd nr mo wmask  exp_wdata                exp_rdata                err lat
    vecs[0]  = '{"st_dword",   1, 32'h10,  3, 0, 64'h1122334455667788, 64'h0,                0, 0, 0, 1, 8'hFF, 64'h1122334455667788, 64'h0,                0, 2};
    vecs[1]  = '{"st_byte",    1, 32'h13,  0, 0, 64'hAB,               64'h0,                0, 0, 0, 1, 8'h08, 64'h00000000AB000000, 64'h0,                0, 2};
    vecs[2]  = '{"ld_half_s",  0, 32'h16,  1, 0, 64'h0,                64'h8001000000000000, 0, 0, 0, 1, 8'h00, 64'h0,                64'hFFFFFFFFFFFF8001, 0, 3};
    vecs[3]  = '{"ld_half_u",  0, 32'h16,  1, 1, 64'h0,                64'h8001000000000000, 0, 0, 0, 1, 8'h00, 64'h0,                64'h0000000000008001, 0, 3};
    vecs[4]  = '{"mis_word",   0, 32'h102, 2, 0, 64'h0,                64'h0,                0, 0, 0, 0, 8'h00, 64'h0,                64'h0,                1, 1};
    vecs[5]  = '{"st_stall",   1, 32'h24,  2, 0, 64'hDEADBEEF,         64'h0,                5, 0, 0, 1, 8'hF0, 64'hDEADBEEF00000000, 64'h0,                0, 7};
    vecs[6]  = '{"ld_stall",   0, 32'h0F,  0, 0, 64'h0,                64'h85AA55AA55AA55AA, 5, 0, 0, 1, 8'h00, 64'h0,                64'hFFFFFFFFFFFFFF85, 0, 8};
    vecs[7]  = '{"ld_timeout", 0, 32'h40,  3, 0, 64'h0,                64'h0,                0, 0, 1, 1, 8'h00, 64'h0,                64'h0,                1, 9};
    vecs[8]  = '{"ld_word_u",  0, 32'h2C,  2, 1, 64'h0,                64'h89ABCDEF01234567, 0, 2, 0, 1, 8'h00, 64'h0,                64'h0000000089ABCDEF, 0, 5};
    vecs[9]  = '{"ld_word_s",  0, 32'h2C,  2, 0, 64'h0,                64'h89ABCDEF01234567, 0, 0, 0, 1, 8'h00, 64'h0,                64'hFFFFFFFF89ABCDEF, 0, 3};
    vecs[10] = '{"ld_dword",   0, 32'h38,  3, 0, 64'h0,                64'h0123456789ABCDEF, 0, 0, 0, 1, 8'h00, 64'h0,                64'h0123456789ABCDEF, 0, 3};
    vecs[11] = '{"mis_half_st",1, 32'h31,  1, 0, 64'h1234,             64'h0,                0, 0, 0, 0, 8'h00, 64'h0,                64'h0,                1, 1};
    vecs[12] = '{"mis_dword",  0, 32'h44,  3, 1, 64'h0,                64'h0,                0, 0, 0, 0, 8'h00, 64'h0,                64'h0,                1, 1};
    vecs[13] = '{"st_half",    1, 32'h3A,  1, 0, 64'h1234,             64'h0,                0, 0, 0, 1, 8'h0C, 64'h0000000012340000, 64'h0,                0, 2};
    vecs[14] = '{"ld_byte_u",  0, 32'h1005,0, 1, 64'h0,                64'h0000F70000000000, 1, 1, 0, 1, 8'h00, 64'h0,                64'h00000000000000F7, 0, 5};

    bus.req_valid    = 1'b0;
    bus.req_wen      = 1'b0;
    bus.req_addr     = '0;
    bus.req_size     = '0;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = '0;
    bus.mem_ready    = 1'b0;
    bus.mem_rvalid   = 1'b0;
    bus.mem_rdata    = '0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int n = 0; n < 15; n++) run_vec(vecs[n]);

    // Reset while a load is waiting for data: access dropped, no response.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_wen      = 1'b0;
    bus.req_addr     = 32'h50;
    bus.req_size     = 2'd3;
    bus.req_unsigned = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    check(bus.mem_valid === 1'b0, "rst_wait/in_wait", 64'(bus.mem_valid), 64'd0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hCAFEF00DCAFEF00D;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check(bus.resp_valid === 1'b0, "late_rvalid/no_resp", 64'(bus.resp_valid), 64'd0);
    end
    run_vec(vecs[10]);
    run_vec(vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
